muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative multiply/divide sequencer for the multicycle MIPS datapath. It replaces the single-cycle combinational MULT/MULTU/DIV/DIVU paths with a 32-iteration shift-add / restoring-divide engine. It owns the architectural HI/LO registers and stalls the main control FSM through busy/done. It also serves MTHI/MTLO writes and continuously drives HI/LO for MFHI/MFLO.

Parameters:
ITER, 32, number of iteration cycles; fixed to the operand width and not to be overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to begin an operation; sampled only in IDLE
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
src0_i  input  32  rs operand (multiplicand / dividend); latched on start
src1_i  input  32  rt operand (multiplier / divisor); latched on start
mthi  input  1  write wdata_i into HI; accepted only in IDLE
mtlo  input  1  write wdata_i into LO; accepted only in IDLE
wdata_i  input  32  data for mthi/mtlo
busy  output  1  high while an operation is in progress; control FSM must hold
done  output  1  one-cycle pulse when the new HI/LO values are visible
hi_o  output  32  HI register (remainder / product upper word)
lo_o  output  32  LO register (quotient / product lower word)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi_o=0, lo_o=0; iteration counter=0; internal operand registers=0. Reset mid-operation aborts immediately. HI/LO are cleared, not partially updated.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On start=1, latch op and operands.
  - For signed ops, store magnitudes |src0_i| and |src1_i| plus sign flags: neg_q = s0^s1, neg_r = s0.
  - Clear counter and go to RUN. busy=1 from the next cycle.
- RUN: exactly 32 cycles, counter 0..31.
  - Multiply: 64-bit accumulator, shift-add, one multiplier bit per cycle, LSB first.
  - Divide: 64-bit remainder/quotient shift register, restoring subtract, one quotient bit per cycle, MSB first.
  - Leave RUN when counter==31.
- FIX: one cycle; apply sign correction, then write HI/LO at the edge leaving FIX.
  - MULT: the 64-bit product is negated if neg_q.
  - DIV: the quotient is negated if neg_q; the remainder is negated if neg_r.
  - All negation is two's complement, modulo 2^32 (or 2^64 for products).
- Timing:
  - done=1 for exactly the one cycle after the FIX->IDLE edge; busy=0 in that same cycle.
  - Latency: start sampled at edge E0; hi_o/lo_o and done change at edge E34.
- Divide by zero (either signedness): no exception. Result is HI=src0_i as latched (original signed value, not magnitude) and LO=32'hFFFF_FFFF. Latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, with no flag. This falls out naturally from magnitude arithmetic wrap.
- While busy:
  - start, mthi and mtlo are ignored (dropped, not queued).
  - hi_o/lo_o keep their previous values until the FIX edge.
- In IDLE with start and mthi/mtlo in the same cycle: start wins and the write is dropped.
- mthi and mtlo together: both registers take wdata_i.
- mthi/mtlo take effect at the next edge. done is not pulsed for them.
- Operands are held internally, so src0_i/src1_i may change freely after the start cycle.
- hi_o/lo_o are direct register outputs with no combinational path from the inputs.

Test Plan:
- MULT src0=0xFFFFFFFD (-3), src1=5 -> busy high 34 cycles, done pulses at E34; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 7/-2 -> LO=0xFFFFFFFD, HI=0x00000001.
- DIVU 0x64/0 -> HI=0x00000064, LO=0xFFFFFFFF after 34 cycles.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 3x4 running, then a second start and an mthi at cycle 10 -> both ignored; HI=0, LO=0xC.
- Afterwards, mthi 0xAAAA5555 in IDLE -> hi_o=0xAAAA5555 next cycle, done stays 0.
- Start DIVU 100/7, then assert rst at cycle 15 -> next cycle busy=0, done=0, HI=LO=0.
- A fresh start after the reset completes normally: LO=14, HI=2.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-cycle shift-add multiplier / restoring divider owning HI/LO.
// A load cycle at the top of RUN forms operand magnitudes, so the result lands 34 edges after start.
module muldiv_sequencer #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src0_i,
    input  logic [31:0] src1_i,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata_i,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        prep_q;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, m_q;
    logic [63:0] acc_q;
    logic        neg_q, negr_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q;
    logic        s0, s1, ge;
    logic [31:0] mag0, mag1, quo_d, rem_d;
    logic [32:0] sum_d, part_d;
    logic [63:0] acc_d, prod_d;
    always_comb begin
        s0     = ~op_q[0] & a_q[31];
        s1     = ~op_q[0] & b_q[31];
        mag0   = s0 ? -a_q : a_q;
        mag1   = s1 ? -b_q : b_q;
        sum_d  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        // partial remainder keeps the bit shifted out of the upper word
        part_d = acc_q[63:31];
        ge     = part_d >= {1'b0, m_q};
        acc_d  = op_q[1] ? {ge ? part_d[31:0] - m_q : part_d[31:0], acc_q[30:0], ge}
                         : {sum_d, acc_q[31:1]};
        prod_d = neg_q ? -acc_q : acc_q;
        quo_d  = neg_q ? -acc_q[31:0] : acc_q[31:0];
        rem_d  = negr_q ? -acc_q[63:32] : acc_q[63:32];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= src0_i;
                        b_q     <= src1_i;
                        cnt_q   <= '0;
                        prep_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        if (mthi) hi_q <= wdata_i;
                        if (mtlo) lo_q <= wdata_i;
                    end
                end
                RUN: begin
                    if (prep_q) begin
                        prep_q <= 1'b0;
                        acc_q  <= {32'd0, op_q[1] ? mag0 : mag1};
                        m_q    <= op_q[1] ? mag1 : mag0;
                        neg_q  <= s0 ^ s1;
                        negr_q <= s0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(ITER - 1)) state_q <= FIX;
                    end
                end
                FIX: begin
                    if (op_q[1] && b_q == '0) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else if (op_q[1]) begin
                        hi_q <= rem_d;
                        lo_q <= quo_d;
                    end else begin
                        {hi_q, lo_q} <= prod_d;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench with directed and random ops against an arithmetic model.
module tb_muldiv_sequencer;
    logic        clk = 0, rst = 1, start = 0, mthi = 0, mtlo = 0;
    logic [1:0]  op = 0;
    logic [31:0] src0 = 0, src1 = 0, wdata = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct { logic [63:0] res; int edge_n; } exp_t;
    exp_t sb[$];

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src0_i(src0), .src1_i(src1),
        .mthi(mthi), .mtlo(mtlo), .wdata_i(wdata), .busy(busy), .done(done),
        .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (o == 2'd0) return 64'(sa * sb_);
        if (o == 2'd1) return {32'd0, a} * {32'd0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd3) return {a % b, a / b};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
    endfunction

    // monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: done=1 with no outstanding request");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.res[63:32]);
                chk("lo", lo, e.res[31:0]);
                chk("done_edge", cyc, e.edge_n);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // inj < 0: none; inj == 0: mthi/mtlo with start; inj > 0: start+mthi+mtlo mid-run
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int inj);
        logic [31:0] ph, pl;
        int bc;
        ph = hi;
        pl = lo;
        sb.push_back('{res, cyc + 35});
        start = 1; op = o; src0 = a; src1 = b;
        if (inj == 0) begin mthi = 1; mtlo = 1; wdata = $urandom; end
        @(negedge clk);
        start = 0; mthi = 0; mtlo = 0;
        src0 = $urandom; src1 = $urandom; op = 2'($urandom);
        bc = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            if (inj > 0 && bc == inj) begin
                start = 1; mthi = 1; mtlo = 1; wdata = $urandom; op = 2'($urandom);
            end
            @(negedge clk);
            bc++;
            start = 0; mthi = 0; mtlo = 0;
            if (inj >= 0 && bc == inj + 1) begin
                chk("hi_held_busy", hi, ph);
                chk("lo_held_busy", lo, pl);
            end
        end
        chk("busy_cycles", bc, 34);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b, w;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, -1);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1);
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, -1);
        do_op(2'd3, 32'h64, 32'd0, 64'h0000_0064_FFFF_FFFF, -1);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, -1);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1);
        do_op(2'd1, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 10);

        mthi = 1; wdata = 32'hAAAA_5555;
        @(negedge clk);
        mthi = 0;
        chk("mthi_hi", hi, 32'hAAAA_5555);
        chk("mthi_lo_kept", lo, 32'hC);
        chk("mthi_no_done", done, 0);
        w = $urandom;
        mthi = 1; mtlo = 1; wdata = w;
        @(negedge clk);
        mthi = 0; mtlo = 0;
        chk("both_hi", hi, w);
        chk("both_lo", lo, w);
        chk("both_no_done", done, 0);

        do_op(2'd0, 32'd6, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 0);

        start = 1; op = 2'd3; src0 = 32'd100; src1 = 32'd7;
        @(negedge clk);
        start = 0;
        repeat (14) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        rst = 0;
        @(negedge clk);
        do_op(2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, -1);

        for (int k = 0; k < 40; k++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            do_op(o, a, b, model(o, a, b), (k % 5 == 0) ? 5 + k % 20 : -1);
        end

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_done: %0d requests never completed", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
